// File: rtl/multicycle_adder.sv
// multicycle_adder: chunk-serial adder/subtractor.
// Processes CHUNK bits per clock, least-significant chunk first.
// A result takes NCHUNK cycles and is held until the consumer accepts it.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding chunk r_cnt each cycle, carry rippled through r_carry
// DONE  | S/Cout/Ovf valid, waiting for out_ready
module multicycle_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK:0]   w_sum;

   // Slice the current chunk of both operands and add it with the running carry.
   // r_b already holds ~B for subtraction, so this is always a plain add.
   always_comb begin
      w_a_chunk = r_a[r_cnt*CHUNK +: CHUNK];
      w_b_chunk = r_b[r_cnt*CHUNK +: CHUNK];
      w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
   end

   // Control FSM, operand capture, chunk datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_s         <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a        <= A;
                  r_b        <= Sub ? ~B : B;
                  // Subtraction is A + ~B + 1 - borrow, i.e. carry-in of ~Cin.
                  r_carry    <= Cin ^ Sub;
                  r_cnt      <= '0;
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
               end
            end
            RUN: begin
               r_s[r_cnt*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
               r_carry                   <= w_sum[CHUNK];
               if (r_cnt == LAST) begin
                  r_cout      <= w_sum[CHUNK];
                  r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                 (w_sum[CHUNK-1] != r_a[WIDTH-1]);
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign S         = r_s;
   assign Cout      = r_cout;
   assign Ovf       = r_ovf;

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, the bits added per clock; WIDTH SHALL be a multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-004 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have A, input, WIDTH, operand A.
REQ-006 SHALL have B, input, WIDTH, operand B.
REQ-007 SHALL have Cin, input, 1, carry-in for add, or borrow-in when Sub=1.
REQ-008 SHALL have Sub, input, 1, mode: 0 computes A+B+Cin, 1 computes A-B-Cin.
REQ-009 SHALL have in_valid, input, 1, operands valid.
REQ-010 SHALL have in_ready, output, 1, block accepts operands.
REQ-011 SHALL have S, output, WIDTH, registered result.
REQ-012 SHALL have Cout, output, 1, raw carry out of the MSB; when Sub=1 it is the not-borrow flag.
REQ-013 SHALL have Ovf, output, 1, two's-complement signed overflow.
REQ-014 SHALL have out_valid, output, 1, S/Cout/Ovf valid.
REQ-015 SHALL have out_ready, input, 1, consumer accepts the result.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-017 SHALL, in IDLE on in_valid=1, capture A into the operand register.
REQ-018 SHALL, on the same accepting edge, capture B into the operand register if Sub=0, or ~B if Sub=1.
REQ-019 SHALL, on the same accepting edge, set the carry register to Cin if Sub=0, or ~Cin if Sub=1.
REQ-020 SHALL, on the same accepting edge, clear the chunk counter to 0 and enter RUN.
REQ-021 SHALL, in RUN, add chunk k each cycle: {carry, S[k*CHUNK +: CHUNK]} = a_chunk + b_chunk + carry, where k = counter value and the carry register updates every cycle.
REQ-022 SHALL, on the RUN edge with counter = NCHUNK-1, register Cout = final carry and Ovf = (a_msb == b_eff_msb) && (S_msb != a_msb), then enter DONE.
REQ-023 SHALL assert out_valid exactly NCHUNK rising edges after the accepting edge (CHUNK=WIDTH gives 1 cycle of latency).
REQ-024 SHALL hold S, Cout and Ovf stable in DONE while out_ready=0.
REQ-025 SHALL leave DONE for IDLE on the edge where out_ready=1, with in_ready=1 in the following cycle; no same-cycle accept of new operands.
REQ-026 SHALL ignore in_valid, A, B, Cin and Sub outside IDLE; operand changes during RUN SHALL NOT affect the result.
REQ-027 SHALL leave S holding the previous result in IDLE and during RUN, where only completed chunks are overwritten; S SHALL be meaningful only while out_valid=1.
REQ-028 SHALL compute results modulo 2^WIDTH, with carry propagating across every chunk boundary, e.g. all-ones + 1.

Reset
REQ-029 SHALL, with rst=1 at an edge, force state IDLE, counter 0, carry 0, S=0, Cout=0, Ovf=0, out_valid=0, with in_ready=1 in the next cycle.
REQ-030 SHALL have rst take priority over all other inputs and abort a RUN or DONE operation with no output produced.

Verification (WIDTH=16, CHUNK=4)
REQ-031 SHALL cover: A=0x1234, B=0x1111, Cin=0, Sub=0 -> S=0x2345, Cout=0, Ovf=0, out_valid high exactly 4 edges after accept.
REQ-032 SHALL cover: A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> S=0x0000, Cout=1, Ovf=0 (carry crosses all chunks).
REQ-033 SHALL cover: A=0x7FFF, B=0x0001, Sub=0 -> S=0x8000, Cout=0, Ovf=1; and A=0x0003, B=0x0005, Cin=0, Sub=1 -> S=0xFFFE, Cout=0, Ovf=0.
REQ-034 SHALL cover: out_ready=0 for 3 cycles in DONE with in_valid pulsed -> out_valid and S held, in_ready=0, no new capture; out_ready=1 -> IDLE on the next edge.
REQ-035 SHALL cover: rst=1 after 2 RUN cycles -> next cycle in_ready=1, out_valid=0, S=0; a subsequent transaction completes correctly.
REQ-036 SHALL cover: CHUNK=16 instance with A=0xFFFF, B=0xFFFF, Cin=1 -> S=0xFFFF, Cout=1, out_valid 1 edge after accept.
